// File: rtl/sync_ram_1r1w.sv
// sync_ram_1r1w
//   Single-clock RAM with one synchronous read port and one write port.
//   Used for instruction memory and similar storage. The storage array is
//   named `mem` so enclosing blocks can preload it by hierarchical
//   reference.
//
//   Optional build macro:
//     RAM_1R1W_SYNC_WRITE_FIRST_EN - when defined, a same-address read and
//       write on the same edge returns the new write data (write-first).
//       When undefined the read returns the old contents (read-first).
//
//   Ports:
//     clk_i       clock, all state updates on the rising edge
//     reset_i     synchronous active-high reset (clears read data only)
//     wr_valid_i  write enable
//     wr_data_i   write data
//     wr_addr_i   write word address (out-of-range writes are dropped)
//     rd_valid_i  read enable; low holds rd_data_o (stall)
//     rd_addr_i   read word address (out-of-range reads return zero)
//     rd_data_o   registered read data, one cycle after the address
module sync_ram_1r1w #(
  parameter int width_p = 32,
  parameter int depth_p = 1024,
  localparam int addr_w_lp = (depth_p > 1) ? $clog2(depth_p) : 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 wr_valid_i,
  input  logic [width_p-1:0]   wr_data_i,
  input  logic [addr_w_lp-1:0] wr_addr_i,
  input  logic                 rd_valid_i,
  input  logic [addr_w_lp-1:0] rd_addr_i,
  output logic [width_p-1:0]   rd_data_o
);

  // One extra bit so depth_p itself is representable when it is a power
  // of two (e.g. 1024 in an 11-bit compare).
  localparam logic [addr_w_lp:0] depth_lp = depth_p[addr_w_lp:0];

  // Contents are deliberately not touched by reset so preloaded programs
  // survive a reset.
  logic [width_p-1:0] mem [0:depth_p-1];

  logic [width_p-1:0] rd_data_p1;
  logic               wr_hit;
  logic               rd_hit;
  logic               bypass;

  function automatic logic addr_in_range(input logic [addr_w_lp-1:0] addr);
    return ({1'b0, addr} < depth_lp);
  endfunction

  assign wr_hit = wr_valid_i && addr_in_range(wr_addr_i);
  assign rd_hit = addr_in_range(rd_addr_i);

`ifdef RAM_1R1W_SYNC_WRITE_FIRST_EN
  // Forward the incoming write data on a same-address collision.
  assign bypass = wr_hit && rd_valid_i && rd_hit && (wr_addr_i == rd_addr_i);
`else
  // Read-first: the nonblocking write lands after the read samples mem.
  assign bypass = 1'b0;
`endif

  // Write port: independent of reset so loads during reset still commit.
  always_ff @(posedge clk_i) begin
    if (wr_hit) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  // ---- stage p0 -> p1: registered read data ----
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_data_p1 <= '0;
    end else if (rd_valid_i) begin
      if (!rd_hit) begin
        rd_data_p1 <= '0;
      end else if (bypass) begin
        rd_data_p1 <= wr_data_i;
      end else begin
        rd_data_p1 <= mem[rd_addr_i];
      end
    end
  end

  assign rd_data_o = rd_data_p1;

endmodule

// File: tb/tb_sync_ram_1r1w.sv
module tb_sync_ram_1r1w;

`ifdef RAM_1R1W_SYNC_WRITE_FIRST_EN
  localparam bit WF = 1'b1;
`else
  localparam bit WF = 1'b0;
`endif

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Big instance: depth 1024
  logic        b_rst, b_wv, b_rv;
  logic [9:0]  b_wa, b_ra;
  logic [31:0] b_wd, b_rd;
  // Small instance: depth 10 (non-power-of-two)
  logic        s_rst, s_wv, s_rv;
  logic [3:0]  s_wa, s_ra;
  logic [31:0] s_wd, s_rd;

  sync_ram_1r1w #(.width_p(32), .depth_p(1024)) u_big (
    .clk_i(clk), .reset_i(b_rst), .wr_valid_i(b_wv), .wr_data_i(b_wd),
    .wr_addr_i(b_wa), .rd_valid_i(b_rv), .rd_addr_i(b_ra), .rd_data_o(b_rd)
  );

  sync_ram_1r1w #(.width_p(32), .depth_p(10)) u_small (
    .clk_i(clk), .reset_i(s_rst), .wr_valid_i(s_wv), .wr_data_i(s_wd),
    .wr_addr_i(s_wa), .rd_valid_i(s_rv), .rd_addr_i(s_ra), .rd_data_o(s_rd)
  );

  // Reference model: plain arrays plus the expected read register.
  logic [31:0] mb [1024];
  logic [31:0] ms [10];
  logic [31:0] exp_b, exp_s;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst;
    logic        wv;
    logic [9:0]  wa;
    logic [31:0] wd;
    logic        rv;
    logic [9:0]  ra;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic rst, logic wv, logic [9:0] wa, logic [31:0] wd,
                              logic rv, logic [9:0] ra, logic chk, logic [31:0] exp);
    vec_t v;
    v.rst = rst; v.wv = wv; v.wa = wa; v.wd = wd;
    v.rv = rv; v.ra = ra; v.chk = chk; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: rd_data_o=%h expected %h", nm, act, exp);
    end
  endtask

  // Advance one clock: predict both instances from the model, then sample
  // 1 time unit after the edge.
  task automatic cycle();
    if (b_rst) exp_b = '0;
    else if (b_rv) exp_b = (WF && b_wv && b_wa == b_ra) ? b_wd : mb[b_ra];
    if (b_wv) mb[b_wa] = b_wd;

    if (s_rst) exp_s = '0;
    else if (s_rv) begin
      if (s_ra >= 4'd10) exp_s = '0;
      else if (WF && s_wv && s_wa == s_ra) exp_s = s_wd;
      else exp_s = ms[s_ra];
    end
    if (s_wv && s_wa < 4'd10) ms[s_wa] = s_wd;

    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] coll_exp;
    coll_exp = WF ? 32'h5555FFFF : 32'hAAAA0000;

    b_rst = 0; b_wv = 0; b_wa = '0; b_wd = '0; b_rv = 0; b_ra = '0;
    s_rst = 1; s_wv = 0; s_wa = '0; s_wd = '0; s_rv = 0; s_ra = '0;

    //            rst wv  wa    wd            rv  ra    chk exp
    vq.push_back(mk(0, 1, 10'd0,    32'h00500093, 0, 10'd0,    0, 32'h0));
    vq.push_back(mk(1, 0, 10'd0,    32'h0,        1, 10'd0,    1, 32'h0));
    vq.push_back(mk(1, 0, 10'd0,    32'h0,        1, 10'd0,    1, 32'h0));
    vq.push_back(mk(0, 0, 10'd0,    32'h0,        1, 10'd0,    1, 32'h00500093));
    vq.push_back(mk(0, 1, 10'd3,    32'hDEADBEEF, 0, 10'd0,    1, 32'h00500093));
    vq.push_back(mk(0, 1, 10'd1023, 32'h12345678, 0, 10'd0,    1, 32'h00500093));
    vq.push_back(mk(0, 0, 10'd0,    32'h0,        1, 10'd3,    1, 32'hDEADBEEF));
    vq.push_back(mk(0, 0, 10'd0,    32'h0,        1, 10'd1023, 1, 32'h12345678));
    vq.push_back(mk(0, 0, 10'd0,    32'h0,        1, 10'd3,    1, 32'hDEADBEEF));
    vq.push_back(mk(0, 1, 10'd3,    32'h0,        0, 10'd1023, 1, 32'hDEADBEEF));
    vq.push_back(mk(0, 0, 10'd0,    32'h0,        0, 10'd1023, 1, 32'hDEADBEEF));
    vq.push_back(mk(0, 0, 10'd0,    32'h0,        0, 10'd1023, 1, 32'hDEADBEEF));
    vq.push_back(mk(0, 0, 10'd0,    32'h0,        0, 10'd1023, 1, 32'hDEADBEEF));
    vq.push_back(mk(0, 0, 10'd0,    32'h0,        1, 10'd1023, 1, 32'h12345678));
    vq.push_back(mk(0, 1, 10'd5,    32'hAAAA0000, 0, 10'd5,    1, 32'h12345678));
    vq.push_back(mk(0, 1, 10'd5,    32'h5555FFFF, 1, 10'd5,    1, coll_exp));
    vq.push_back(mk(0, 0, 10'd0,    32'h0,        1, 10'd5,    1, 32'h5555FFFF));
    vq.push_back(mk(0, 1, 10'd7,    32'hCAFEF00D, 1, 10'd3,    1, 32'h0));
    vq.push_back(mk(1, 1, 10'd7,    32'h0BADC0DE, 1, 10'd7,    1, 32'h0));
    vq.push_back(mk(0, 0, 10'd0,    32'h0,        1, 10'd7,    1, 32'h0BADC0DE));

    foreach (vq[i]) begin
      b_rst = vq[i].rst; b_wv = vq[i].wv; b_wa = vq[i].wa; b_wd = vq[i].wd;
      b_rv = vq[i].rv; b_ra = vq[i].ra;
      cycle();
      if (vq[i].chk) check($sformatf("vec%0d", i), b_rd, vq[i].exp);
    end
    b_wv = 0; b_rv = 0;

    // Small instance has been held in reset throughout.
    check("small_reset", s_rd, 32'h0);

    // Fill every in-range location, then an out-of-range write.
    s_rst = 0;
    for (int i = 0; i < 10; i++) begin
      s_wv = 1; s_wa = 4'(i); s_wd = 32'h100 + 32'(i);
      cycle();
    end
    s_wa = 4'd12; s_wd = 32'hFFFFFFFF;
    cycle();
    s_wv = 0;
    for (int i = 0; i < 16; i++) begin
      s_rv = 1; s_ra = 4'(i);
      cycle();
      check($sformatf("small_rd%0d", i), s_rd, (i < 10) ? 32'h100 + 32'(i) : 32'h0);
    end
    s_rv = 0; s_wv = 1; s_wa = 4'd9; s_wd = 32'h9;
    cycle();
    s_wv = 0; s_rv = 1; s_ra = 4'd9;
    cycle();
    check("small_rd9_after_write", s_rd, 32'h9);
    s_rv = 1; s_ra = 4'd12;
    cycle();
    check("small_rd12_oob", s_rd, 32'h0);

    // Prewrite the random address pool of the big instance.
    s_rv = 0;
    for (int i = 0; i < 16; i++) begin
      b_wv = 1; b_wa = (i < 8) ? 10'(i) : 10'(1008 + i); b_wd = $urandom;
      cycle();
    end

    // Randomized traffic on both instances against the model.
    for (int n = 0; n < 400; n++) begin
      b_rst = ($urandom_range(0, 15) == 0);
      b_wv  = $urandom_range(0, 1) == 1;
      b_wa  = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 7)) : 10'($urandom_range(1016, 1023));
      b_wd  = $urandom;
      b_rv  = $urandom_range(0, 3) != 0;
      b_ra  = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 7)) : 10'($urandom_range(1016, 1023));
      s_rst = ($urandom_range(0, 15) == 0);
      s_wv  = $urandom_range(0, 1) == 1;
      s_wa  = 4'($urandom_range(0, 15));
      s_wd  = $urandom;
      s_rv  = $urandom_range(0, 3) != 0;
      s_ra  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) s_ra = s_wa;
      if ($urandom_range(0, 3) == 0) b_ra = b_wa;
      cycle();
      check("rand_big", b_rd, exp_b);
      check("rand_small", s_rd, exp_s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
